// File: rtl/rnd_pkg.sv
// Shared types and constants for the LFSR random-symbol stream generator.
package rnd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rnd_state_e;

  localparam logic [5:0] DEFAULT_TAPS = 6'b110000;

  // A zero burst-length request means the full 2^cnt_width burst.
  function automatic int unsigned eff_burst_len(input int unsigned num_steps,
                                                input int unsigned cnt_width);
    return (num_steps == 0) ? (32'd1 << cnt_width) : num_steps;
  endfunction

endpackage

// File: rtl/rnd_lfsr_core.sv
// Fibonacci LFSR register: seed load with zero substitution, single-step advance.
module rnd_lfsr_core #(
  parameter int                   REG_WIDTH = 6,
  parameter logic [REG_WIDTH-1:0] TAPS      = 6'b110000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [REG_WIDTH-1:0] seed,
  output logic [REG_WIDTH-1:0] lfsr
);

  logic feedback;

  assign feedback = ^(lfsr & TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= REG_WIDTH'(1);
    end else if (load) begin
      // An all-zero register would lock up, so a zero seed becomes 1.
      lfsr <= (seed == '0) ? REG_WIDTH'(1) : seed;
    end else if (advance) begin
      lfsr <= {lfsr[REG_WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/rnd_lfsr_stream.sv
// Burst controller: accepts a start in IDLE, streams num_steps LFSR symbols, pulses done.
// Handshake: start_rnd is a request sampled only in IDLE; x_valid marks each symbol, no backpressure.
module rnd_lfsr_stream
  import rnd_pkg::*;
#(
  parameter int                   REG_WIDTH = 6,
  parameter int                   CNT_WIDTH = 3,
  parameter int                   OUT_WIDTH = 2,
  parameter logic [REG_WIDTH-1:0] TAPS      = DEFAULT_TAPS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_rnd,
  input  logic                 reseed,
  input  logic [REG_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0] num_steps,
  output logic                 busy,
  output logic                 x_valid,
  output logic [OUT_WIDTH-1:0] x_out,
  output logic                 done_rnd,
  output rnd_state_e           state_dbg,
  output logic [REG_WIDTH-1:0] lfsr_dbg
);

  localparam int CW1 = CNT_WIDTH + 1;

  rnd_state_e           state;
  logic [CW1-1:0]       cnt;
  logic [REG_WIDTH-1:0] lfsr;
  logic                 accept;
  logic                 load;
  logic                 advance;

  assign accept  = (state == IDLE) && start_rnd;
  assign load    = accept && reseed;
  assign advance = (state == RUN);

  rnd_lfsr_core #(
    .REG_WIDTH (REG_WIDTH),
    .TAPS      (TAPS)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .seed    (seed),
    .lfsr    (lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rnd) begin
            cnt   <= CW1'(eff_burst_len(32'(num_steps), CNT_WIDTH));
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt - CW1'(1);
          if (cnt == CW1'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state and the LFSR register only.
  assign busy      = (state != IDLE);
  assign x_valid   = (state == RUN);
  assign x_out     = x_valid ? lfsr[REG_WIDTH-1 -: OUT_WIDTH] : '0;
  assign done_rnd  = (state == DONE);
  assign state_dbg = state;
  assign lfsr_dbg  = lfsr;

endmodule

// File: tb/tb_rnd_lfsr_stream.sv
// Directed bench for rnd_lfsr_stream: default 6-bit instance plus two 16-bit instances.
module tb_rnd_lfsr_stream;
  import rnd_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Instance A: defaults (6-bit register, 3-bit count, 2-bit symbols).
  logic       start_a, reseed_a;
  logic [5:0] seed_a;
  logic [2:0] steps_a;
  logic       busy_a, xv_a, done_a;
  logic [1:0] xo_a;
  rnd_state_e st_a;
  logic [5:0] lfsr_a;

  // Instance B: 16-bit maximal taps, 3-bit count.
  logic        start_b, reseed_b;
  logic [15:0] seed_b;
  logic [2:0]  steps_b;
  logic        busy_b, xv_b, done_b;
  logic [3:0]  xo_b;
  rnd_state_e  st_b;
  logic [15:0] lfsr_b;

  // Instance C: 16-bit maximal taps, 16-bit count for the full-period run.
  logic        start_c, reseed_c;
  logic [15:0] seed_c;
  logic [15:0] steps_c;
  logic        busy_c, xv_c, done_c;
  logic [3:0]  xo_c;
  rnd_state_e  st_c;
  logic [15:0] lfsr_c;

  rnd_lfsr_stream u_dut_a (
    .clk(clk), .rst(rst), .start_rnd(start_a), .reseed(reseed_a), .seed(seed_a),
    .num_steps(steps_a), .busy(busy_a), .x_valid(xv_a), .x_out(xo_a),
    .done_rnd(done_a), .state_dbg(st_a), .lfsr_dbg(lfsr_a)
  );

  rnd_lfsr_stream #(.REG_WIDTH(16), .CNT_WIDTH(3), .OUT_WIDTH(4), .TAPS(16'hB400)) u_dut_b (
    .clk(clk), .rst(rst), .start_rnd(start_b), .reseed(reseed_b), .seed(seed_b),
    .num_steps(steps_b), .busy(busy_b), .x_valid(xv_b), .x_out(xo_b),
    .done_rnd(done_b), .state_dbg(st_b), .lfsr_dbg(lfsr_b)
  );

  rnd_lfsr_stream #(.REG_WIDTH(16), .CNT_WIDTH(16), .OUT_WIDTH(4), .TAPS(16'hB400)) u_dut_c (
    .clk(clk), .rst(rst), .start_rnd(start_c), .reseed(reseed_c), .seed(seed_c),
    .num_steps(steps_c), .busy(busy_c), .x_valid(xv_c), .x_out(xo_c),
    .done_rnd(done_c), .state_dbg(st_c), .lfsr_dbg(lfsr_c)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] next16(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start_a = 0; reseed_a = 0; seed_a = '0; steps_a = '0;
    start_b = 0; reseed_b = 0; seed_b = '0; steps_b = '0;
    start_c = 0; reseed_c = 0; seed_c = '0; steps_c = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, xv_a, xo_a, done_a} !== 5'b0) begin
      errors++; $display("FAIL reset_outs_a got %b exp 00000", {busy_a, xv_a, xo_a, done_a});
    end
    checks++;
    if (lfsr_a !== 6'd1 || st_a !== IDLE) begin
      errors++; $display("FAIL reset_state_a got lfsr %b st %0d exp 000001 st 0", lfsr_a, st_a);
    end
    checks++;
    if ({busy_b, xv_b, xo_b, done_b, busy_c, xv_c, xo_c, done_c} !== 14'b0 ||
        lfsr_b !== 16'd1 || lfsr_c !== 16'd1) begin
      errors++; $display("FAIL reset_wide got lfsr_b %h lfsr_c %h exp 0001 outs 0", lfsr_b, lfsr_c);
    end
    rst = 1'b1;
  endtask

  // Runs one burst on instance A starting at the current negedge; checks symbols, done and final lfsr.
  task automatic run_burst_a(input string name, input logic rs, input logic [5:0] sd,
                             input logic [2:0] ns, input int n, input logic [15:0] syms,
                             input logic [5:0] final_lfsr);
    start_a = 1'b1; reseed_a = rs; seed_a = sd; steps_a = ns;
    @(negedge clk);
    start_a = 1'b0; seed_a = 6'b101010; steps_a = 3'd5; reseed_a = ~rs;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (xv_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 || xo_a !== syms[15-2*i -: 2]) begin
        errors++;
        $display("FAIL %s_sym%0d got v%b b%b d%b x%b exp v1 b1 d0 x%b", name, i, xv_a, busy_a,
                 done_a, xo_a, syms[15-2*i -: 2]);
      end
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1 || xv_a !== 1'b0 || xo_a !== 2'b00 || lfsr_a !== final_lfsr) begin
      errors++;
      $display("FAIL %s_done got d%b b%b v%b x%b lfsr %b exp d1 b1 v0 x00 lfsr %b", name, done_a,
               busy_a, xv_a, xo_a, lfsr_a, final_lfsr);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || st_a !== IDLE) begin
      errors++; $display("FAIL %s_idle got d%b b%b st %0d exp d0 b0 st 0", name, done_a, busy_a, st_a);
    end
  endtask

  task automatic test_seeded_burst();
    run_burst_a("seeded8", 1'b1, 6'b000111, 3'd0, 8, 16'b00_00_01_11_11_10_00_01, 6'b100101);
  endtask

  task automatic test_continue();
    run_burst_a("continue2", 1'b0, 6'b111111, 3'd2, 2, 16'b10_00_000000000000, 6'b010110);
  endtask

  task automatic test_zero_seed();
    start_a = 1'b1; reseed_a = 1'b1; seed_a = 6'b000000; steps_a = 3'd1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (lfsr_a !== 6'b000001 || xo_a !== 2'b00 || xv_a !== 1'b1) begin
      errors++; $display("FAIL zero_seed_load got lfsr %b x%b v%b exp 000001 x00 v1", lfsr_a, xo_a, xv_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1 || xv_a !== 1'b0 || lfsr_a !== 6'b000010) begin
      errors++; $display("FAIL zero_seed_done got d%b v%b lfsr %b exp d1 v0 000010", done_a, xv_a, lfsr_a);
    end
    @(negedge clk);
  endtask

  // start_rnd held high: each accepted start yields exactly 3 symbols, then one IDLE cycle.
  task automatic test_back_to_back();
    logic [1:0] exp_sym[6];
    exp_sym = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11};
    start_a = 1'b1; reseed_a = 1'b1; seed_a = 6'b000111; steps_a = 3'd3;
    @(negedge clk);
    seed_a = 6'b011100;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xv_a !== 1'b1 || done_a !== 1'b0 || xo_a !== exp_sym[b*3+i]) begin
          errors++;
          $display("FAIL b2b_burst%0d_sym%0d got v%b d%b x%b exp v1 d0 x%b", b, i, xv_a, done_a,
                   xo_a, exp_sym[b*3+i]);
        end
        @(negedge clk);
      end
      if (b == 1) start_a = 1'b0;
      checks++;
      if (done_a !== 1'b1 || xv_a !== 1'b0 || busy_a !== 1'b1) begin
        errors++; $display("FAIL b2b_done%0d got d%b v%b b%b exp d1 v0 b1", b, done_a, xv_a, busy_a);
      end
      @(negedge clk);
      checks++;
      if (st_a !== IDLE || busy_a !== 1'b0 || done_a !== 1'b0) begin
        errors++; $display("FAIL b2b_gap%0d got st %0d b%b d%b exp st 0 b0 d0", b, st_a, busy_a, done_a);
      end
      @(negedge clk);
    end
    checks++;
    if (st_a !== IDLE || xv_a !== 1'b0) begin
      errors++; $display("FAIL b2b_no_queue got st %0d v%b exp st 0 v0", st_a, xv_a);
    end
  endtask

  task automatic test_mid_reset();
    start_a = 1'b1; reseed_a = 1'b1; seed_a = 6'b000111; steps_a = 3'd0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (xo_a !== 2'b11 || xv_a !== 1'b1) begin
      errors++; $display("FAIL midrst_sym4 got v%b x%b exp v1 x11", xv_a, xo_a);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy_a, xv_a, xo_a, done_a} !== 5'b0 || lfsr_a !== 6'd1 || st_a !== IDLE) begin
      errors++;
      $display("FAIL midrst_async got outs %b lfsr %b st %0d exp 00000 000001 0",
               {busy_a, xv_a, xo_a, done_a}, lfsr_a, st_a);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet%0d got d%b b%b exp d0 b0", i, done_a, busy_a);
      end
      @(negedge clk);
    end
    run_burst_a("post_rst", 1'b1, 6'b000111, 3'd2, 2, 16'b00_00_000000000000, 6'b011100);
  endtask

  task automatic test_wide_burst();
    logic [15:0] m;
    m = 16'hACE1;
    start_b = 1'b1; reseed_b = 1'b1; seed_b = m; steps_b = 3'd0;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if (xo_b !== 4'hA) begin
      errors++; $display("FAIL wide_first got x%h exp A", xo_b);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (xv_b !== 1'b1 || xo_b !== m[15:12]) begin
        errors++; $display("FAIL wide_sym%0d got v%b x%h exp v1 x%h", i, xv_b, xo_b, m[15:12]);
      end
      m = next16(m);
      @(negedge clk);
    end
    checks++;
    if (done_b !== 1'b1 || lfsr_b !== m) begin
      errors++; $display("FAIL wide_done got d%b lfsr %h exp d1 lfsr %h", done_b, lfsr_b, m);
    end
    @(negedge clk);
  endtask

  task automatic test_full_period();
    logic [15:0] m;
    int zero_hits;
    int cyc;
    zero_hits = 0;
    cyc = 0;
    m = 16'h0001;
    start_c = 1'b1; reseed_c = 1'b1; seed_c = 16'h0000; steps_c = 16'hFFFF;
    @(negedge clk);
    start_c = 1'b0;
    while (xv_c === 1'b1 && cyc < 70000) begin
      if (lfsr_c === 16'h0000) zero_hits++;
      m = next16(m);
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 65535) begin
      errors++; $display("FAIL period_len got %0d cycles exp 65535", cyc);
    end
    checks++;
    if (zero_hits !== 0) begin
      errors++; $display("FAIL period_nonzero got %0d zero states exp 0", zero_hits);
    end
    checks++;
    if (done_c !== 1'b1 || lfsr_c !== m || lfsr_c !== 16'h0001) begin
      errors++; $display("FAIL period_wrap got d%b lfsr %h exp d1 lfsr 0001 (model %h)", done_c, lfsr_c, m);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_seeded_burst();
    test_continue();
    test_zero_seed();
    test_back_to_back();
    test_mid_reset();
    test_wide_burst();
    test_full_period();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rnd_lfsr_stream.md
# rnd_lfsr_stream

Parametrised LFSR random-symbol generator for the hash datapath, successor to the fixed 6-bit/2-bit generator. On a start request it optionally loads a seed, then emits a programmable-length burst of OUT_WIDTH-bit symbols, one per cycle with a valid strobe, and pulses done. Register width, feedback taps, symbol width and burst length are all configurable. A continue mode resumes the sequence from the current register state without reseeding.

## Interface
- REG_WIDTH, 6, LFSR register width (≥3)
- CNT_WIDTH, 3, width of burst-length field; max burst 2^CNT_WIDTH
- OUT_WIDTH, 2, symbol width (1..REG_WIDTH)
- TAPS, 6'b110000, REG_WIDTH-bit feedback mask (Fibonacci, XOR of masked bits)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- start_rnd  in  1  burst request, sampled only in IDLE
- reseed  in  1  sampled with start_rnd: 1 = load seed, 0 = continue from current register
- seed  in  REG_WIDTH  seed value
- num_steps  in  CNT_WIDTH  burst length; 0 means 2^CNT_WIDTH
- busy  out  1  high in RUN and DONE
- x_valid  out  1  high for each symbol cycle
- x_out  out  OUT_WIDTH  current symbol
- done_rnd  out  1  one-cycle end-of-burst pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE & start_rnd at edge: lfsr ← (reseed ? (seed==0 ? 1 : seed) : lfsr); cnt ← (num_steps==0 ? 2^CNT_WIDTH : num_steps); → RUN.
- RUN, each cycle: x_valid=1; x_out = lfsr[REG_WIDTH-1 -: OUT_WIDTH] (pre-shift value); at edge lfsr ← {lfsr[REG_WIDTH-2:0], ^(lfsr & TAPS)}, cnt ← cnt−1; when cnt==1 → DONE.
- DONE: done_rnd=1 for exactly one cycle, → IDLE.
- All-zero seed replaced by 1 (avoids lock-up); register never reaches zero for nonzero TAPS with bit REG_WIDTH-1 set.
- start_rnd in RUN or DONE ignored (not queued); seed/num_steps/reseed only sampled at acceptance.
- Outside RUN: x_valid=0, x_out = 0.
- Counter is CNT_WIDTH+1 bits wide; no wrap.

## Timing
- Reset (rst=0, async): state IDLE, lfsr = 1, cnt = 0, busy=0, x_valid=0, x_out=0, done_rnd=0.
- Reset mid-burst aborts immediately; no done_rnd pulse.
- Start accepted at edge k: x_valid high in cycles k+1..k+N, done_rnd in cycle k+N+1, busy high k+1..k+N+1.
- Earliest next acceptance: edge ending the DONE cycle is not an acceptance edge; next start sampled at edge k+N+2 (one IDLE cycle minimum between bursts).
- All outputs decoded from registers only; no combinational path from inputs to outputs.

## Structure
- Package rnd_pkg: state enum typedef (IDLE, RUN, DONE), default TAPS constant for REG_WIDTH=6, helper for effective burst length.
- Sub-module rnd_lfsr_core: REG_WIDTH register, load/advance enables, feedback XOR, zero-seed substitution. Top holds FSM, counter, output decode.

## Test plan
- Reset then seed=000111, reseed=1, num_steps=0 (8 steps), defaults → x_out 00,00,01,11,11,10,00,01 on 8 x_valid cycles, done_rnd next cycle, final lfsr 100101.
- Immediately follow with reseed=0, num_steps=2 → x_out 10,00, lfsr ends 010110, single done pulse.
- seed=000000, reseed=1, num_steps=1 → one symbol 00 (register 000001), done after 1 symbol.
- start_rnd held high throughout a num_steps=3 burst → exactly 3 symbols and one done per accepted start; second burst begins only after one IDLE cycle.
- Assert rst low during 4th symbol of an 8-step burst → outputs 0 asynchronously, no done_rnd, busy=0; subsequent start works normally.
- REG_WIDTH=16, OUT_WIDTH=4, TAPS=16'hB400 (maximal), num_steps=0 with CNT_WIDTH=3 → 8 symbols matching bench reference model; lfsr never zero over 65535 advances in a long continue-mode run.
